bit_unstuff: RTL and testbench
==============================

# bit_unstuff

Receive-side counterpart of the transmit bit stuffer. It takes the serial line bit stream and removes the zero the transmitter inserts after every RUN_LEN consecutive ones. It flags a stuffing violation and assembles the surviving data bits LSB-first into bytes for the downstream packet logic. It sits between the line sampler, which supplies one bit per `in_valid` strobe, and the byte-level receiver.

## Interface
- RUN_LEN, 6, number of consecutive data ones after which the transmitter inserts a stuffed zero; legal range 1–14; counter width is $clog2(RUN_LEN+1)

- clk  in  1  single clock, all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- clear  in  1  synchronous packet-boundary restart; clears the run count, byte assembly, `stuff_err` and NRZI history
- in_valid  in  1  `inb` carries a line bit this cycle
- inb  in  1  line bit
- outb  out  1  destuffed data bit, registered
- out_valid  out  1  `outb` valid; one-cycle pulse per emitted data bit
- byte_out  out  8  last completed byte, LSB = first received bit; holds until the next byte completes
- byte_valid  out  1  one-cycle pulse when `byte_out` updates
- stuff_err  out  1  sticky stuffing-violation flag

## Operation
- Decoded bit d = `inb`, or the NRZI-decoded value when `NRZI_DEC_EN` is defined.
- State:
  - run counter `ones_cnt` (0..RUN_LEN)
  - bit index `bit_idx` (0..7)
  - 8-bit shift register
  - NRZI `prev_level`
- On a cycle with in_valid=1 and clear=0:
  - `ones_cnt` == RUN_LEN, d=0: the bit is a stuffed bit and is dropped; ones_cnt←0; no out_valid.
  - `ones_cnt` == RUN_LEN, d=1: stuffing violation. The bit is dropped, stuff_err←1, ones_cnt←0, no out_valid.
  - otherwise: emit d. outb←d, out_valid←1. ones_cnt←ones_cnt+1 if d=1, else 0. Shift d into the assembly register at position bit_idx.
    - If bit_idx==7: byte_out←assembled byte including d, byte_valid←1, bit_idx←0.
    - Else: bit_idx++.
- On a cycle with in_valid=0: out_valid←0, byte_valid←0; all other state holds; outb and byte_out hold.
- `clear`=1 has priority over `in_valid`. Any bit presented in the same cycle is discarded. ones_cnt←0, bit_idx←0, shift register←0, stuff_err←0, prev_level←1, out_valid←0, byte_valid←0. byte_out holds.
- stuff_err stays set across further bits until `clear` or `rst`. Bit processing continues after an error.
- The stuffed bit never contributes to `bit_idx`. A stuffed zero at a byte boundary does not delay or split byte completion beyond its own slot.

## Timing
- Latency: in_valid on cycle N produces out_valid/outb/byte_valid/stuff_err on cycle N+1, all registered.
- Back-to-back in_valid every cycle is supported, giving full throughput of one bit per clock.
- byte_valid is coincident with the out_valid of the 8th data bit.
- Reset values take effect immediately on rst assertion, independent of clk:
  - outb 0, out_valid 0, byte_out 8'h00, byte_valid 0, stuff_err 0
  - ones_cnt 0, bit_idx 0, prev_level 1
- rst mid-byte discards the partial byte. The first bit after reset deasserts starts a new byte at index 0.

## Configuration
- `NRZI_DEC_EN` defined: d = (inb == prev_level) ? 1 : 0.
  - prev_level←inb on every in_valid, including stuffed and violating bits.
  - prev_level resets and clears to 1 (idle level).
- `NRZI_DEC_EN` undefined: d = inb. No prev_level register is present.

## Test plan
- RUN_LEN=6, raw mode: inputs 1,1,1,1,1,1,0,1 → six out_valid pulses with outb=1, no pulse for the 0, then outb=1; stuff_err stays 0.
- Inputs 1×7 → stuff_err=1 one cycle after the 7th bit; the 7th bit produces no out_valid. stuff_err remains 1 through 10 further bits until clear=1, then reads 0 the next cycle.
- Inputs 1,0,1,0,0,1,0,1 with in_valid gaps of 0–3 cycles → exactly one byte_valid, byte_out=8'hA5, coincident with the 8th out_valid.
- Inputs 1,1,1,1,1,1,0,1,1 back-to-back → byte_out=8'hFF, byte_valid on the cycle after the 9th input, eight out_valid pulses total.
- 3 bits, then clear together with in_valid=1 and inb=1, then bits of 8'h3C LSB-first → single byte_valid with 8'h3C; the clear-cycle bit is ignored.
- With `NRZI_DEC_EN`: line 1,1,0,0,1 after reset → decoded 1,1,0,1,0. Also assert rst mid-byte → every output reads its reset value in the same cycle, before any clk edge.

Source files
------------

// File: rtl/bit_unstuff.sv
// Purpose: receive-side bit destuffer. Drops the zero inserted after RUN_LEN ones, flags violations, packs data bits LSB-first into bytes.
// Latency: one cycle from an accepted line bit to out_valid/outb/byte_valid/stuff_err, all registered.
// Backpressure: none; accepts one line bit per clock whenever in_valid is high. Optional NRZI decode via `NRZI_DEC_EN`.
module bit_unstuff #(
    parameter int RUN_LEN = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       in_valid,
    input  logic       inb,
    output logic       outb,
    output logic       out_valid,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       stuff_err
);

    localparam int CW = $clog2(RUN_LEN + 1);
    localparam logic [CW-1:0] RUN_MAX = CW'(RUN_LEN);

    logic [CW-1:0] ones_cnt;
    logic [CW-1:0] ones_cnt_nxt;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_idx_nxt;
    logic [7:0]    asm_q;
    logic [7:0]    asm_nxt;
    logic          d;
    logic          take;
    logic          at_limit;
    logic          emit;
    logic          viol;
    logic          byte_done;

`ifdef NRZI_DEC_EN
    logic prev_level;

    // A repeated line level decodes as 1, a transition as 0.
    assign d = (inb == prev_level);

    // Line level history follows every accepted bit, stuffed or not; idle level is 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_level <= 1'b1;
        end else if (clear) begin
            prev_level <= 1'b1;
        end else if (in_valid) begin
            prev_level <= inb;
        end
    end
`else
    assign d = inb;
`endif

    // Classify the incoming bit and compute next run count, bit index and assembly contents.
    always_comb begin
        take         = in_valid & ~clear;
        at_limit     = (ones_cnt == RUN_MAX);
        emit         = take & ~at_limit;
        viol         = take & at_limit & d;
        byte_done    = emit & (bit_idx == 3'd7);
        ones_cnt_nxt = ones_cnt;
        bit_idx_nxt  = bit_idx;
        asm_nxt      = asm_q;
        if (clear) begin
            ones_cnt_nxt = '0;
            bit_idx_nxt  = 3'd0;
            asm_nxt      = 8'h00;
        end else if (take) begin
            if (at_limit) begin
                // Slot after a full run: stuffed zero or violation, never data.
                ones_cnt_nxt = '0;
            end else begin
                ones_cnt_nxt     = d ? (ones_cnt + CW'(1)) : '0;
                asm_nxt[bit_idx] = d;
                bit_idx_nxt      = (bit_idx == 3'd7) ? 3'd0 : (bit_idx + 3'd1);
            end
        end
    end

    // Internal run/byte tracking state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ones_cnt <= '0;
            bit_idx  <= 3'd0;
            asm_q    <= 8'h00;
        end else begin
            ones_cnt <= ones_cnt_nxt;
            bit_idx  <= bit_idx_nxt;
            asm_q    <= asm_nxt;
        end
    end

    // Registered outputs; outb and byte_out hold between updates, error is sticky until clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outb       <= 1'b0;
            out_valid  <= 1'b0;
            byte_out   <= 8'h00;
            byte_valid <= 1'b0;
            stuff_err  <= 1'b0;
        end else begin
            out_valid  <= emit;
            byte_valid <= byte_done;
            if (emit) begin
                outb <= d;
            end
            if (byte_done) begin
                byte_out <= asm_nxt;
            end
            if (clear) begin
                stuff_err <= 1'b0;
            end else if (viol) begin
                stuff_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bit_unstuff.sv
// Testbench for bit_unstuff: directed scenarios plus randomized line streams checked against a stream-level reference.
// Outputs are sampled 1 time unit after each rising edge; inputs change at the same point.
// Compile with +define+NRZI_DEC_EN to exercise the NRZI build.
module tb_bit_unstuff;

    localparam int RUN_LEN = 6;

    logic       clk;
    logic       rst;
    logic       clear;
    logic       in_valid;
    logic       inb;
    logic       outb;
    logic       out_valid;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       stuff_err;

    int checks;
    int passes;
    int fails;

    bit         raw_q[$];
    bit         got_bits[$];
    logic [7:0] got_bytes[$];
    bit         exp_bits[$];
    bit         exp_err;

    bit_unstuff #(.RUN_LEN(RUN_LEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .inb       (inb),
        .outb      (outb),
        .out_valid (out_valid),
        .byte_out  (byte_out),
        .byte_valid(byte_valid),
        .stuff_err (stuff_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: decode the whole line stream, then remove the slot following every run of RUN_LEN data ones.
    function automatic void run_model();
        int run;
        bit dd;
`ifdef NRZI_DEC_EN
        bit prev;
        prev = 1'b1;
`endif
        exp_bits.delete();
        exp_err = 1'b0;
        run = 0;
        foreach (raw_q[i]) begin
`ifdef NRZI_DEC_EN
            dd = (raw_q[i] == prev);
            prev = raw_q[i];
`else
            dd = raw_q[i];
`endif
            if (run == RUN_LEN) begin
                if (dd) exp_err = 1'b1;
                run = 0;
            end else begin
                exp_bits.push_back(dd);
                run = dd ? run + 1 : 0;
            end
        end
    endfunction

    task automatic sample();
        if (out_valid) got_bits.push_back(outb);
        if (byte_valid) got_bytes.push_back(byte_out);
        check("bv_with_ov", 32'(byte_valid & ~out_valid), 32'd0);
    endtask

    task automatic begin_seg();
        raw_q.delete();
        got_bits.delete();
        got_bytes.delete();
    endtask

    task automatic send(input bit b, input int gap);
        clear    = 1'b0;
        in_valid = 1'b1;
        inb      = b;
        raw_q.push_back(b);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sample();
        for (int g = 0; g < gap; g++) begin
            @(posedge clk);
            #1;
            check("idle_ov", 32'(out_valid), 32'd0);
            check("idle_bv", 32'(byte_valid), 32'd0);
        end
    endtask

    task automatic send_byte(input logic [7:0] v, input int maxgap);
        logic [7:0] t;
        t = v;
        for (int j = 0; j < 8; j++) send(t[j], $urandom_range(0, maxgap));
    endtask

    task automatic do_clear(input bit with_bit, input bit b);
        clear    = 1'b1;
        in_valid = with_bit;
        inb      = b;
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clr_ov", 32'(out_valid), 32'd0);
        check("clr_bv", 32'(byte_valid), 32'd0);
        check("clr_err", 32'(stuff_err), 32'd0);
    endtask

    task automatic end_seg(input string tag);
        int nb;
        logic [7:0] eb;
        run_model();
        check({tag, "_nbits"}, 32'(got_bits.size()), 32'(exp_bits.size()));
        for (int i = 0; i < exp_bits.size() && i < got_bits.size(); i++)
            check($sformatf("%s_bit%0d", tag, i), 32'(got_bits[i]), 32'(exp_bits[i]));
        nb = exp_bits.size() / 8;
        check({tag, "_nbytes"}, 32'(got_bytes.size()), 32'(nb));
        for (int k = 0; k < nb && k < got_bytes.size(); k++) begin
            eb = 8'h00;
            for (int j = 0; j < 8; j++) eb[j] = exp_bits[8*k+j];
            check($sformatf("%s_byte%0d", tag, k), 32'(got_bytes[k]), 32'(eb));
        end
        check({tag, "_err"}, 32'(stuff_err), 32'(exp_err));
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_outb"}, 32'(outb), 32'd0);
        check({tag, "_ov"}, 32'(out_valid), 32'd0);
        check({tag, "_byte"}, 32'(byte_out), 32'h00);
        check({tag, "_bv"}, 32'(byte_valid), 32'd0);
        check({tag, "_err"}, 32'(stuff_err), 32'd0);
    endtask

    initial begin
        bit p[];
        checks   = 0;
        passes   = 0;
        fails    = 0;
        rst      = 1'b1;
        clear    = 1'b0;
        in_valid = 1'b0;
        inb      = 1'b0;

        // Reset values before any clock edge
        #3;
        check_reset_outs("rst0");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outs("rst1");

        // Stuffed zero after six ones is dropped
        begin_seg();
        p = '{1, 1, 1, 1, 1, 1, 0, 1};
        foreach (p[i]) send(p[i], 0);
`ifndef NRZI_DEC_EN
        check("stuff_count", 32'(got_bits.size()), 32'd7);
`endif
        end_seg("stuff");
        do_clear(1'b0, 1'b0);

        // Seven ones: violation, sticky through ten more bits, cleared by clear
        begin_seg();
        for (int i = 0; i < 6; i++) send(1'b1, 0);
        send(1'b1, 0);
        check("viol_err", 32'(stuff_err), 32'd1);
        check("viol_ov", 32'(out_valid), 32'd0);
        check("viol_count", 32'(got_bits.size()), 32'd6);
        for (int i = 0; i < 10; i++) begin
            send(1'b0, 0);
            check("viol_sticky", 32'(stuff_err), 32'd1);
        end
        end_seg("viol");
        do_clear(1'b0, 1'b0);

        // 0xA5 with idle gaps between bits
        begin_seg();
        p = '{1, 0, 1, 0, 0, 1, 0, 1};
        foreach (p[i]) send(p[i], $urandom_range(0, 3));
`ifndef NRZI_DEC_EN
        check("a5_nbytes", 32'(got_bytes.size()), 32'd1);
        if (got_bytes.size() > 0) check("a5_val", 32'(got_bytes[0]), 32'hA5);
`endif
        end_seg("a5");
        do_clear(1'b0, 1'b0);

        // Stuffed zero inside a byte: completion on the cycle after the ninth input
        begin_seg();
        p = '{1, 1, 1, 1, 1, 1, 0, 1, 1};
        foreach (p[i]) begin
            send(p[i], 0);
            if (i < 8) check("ff_bv_early", 32'(byte_valid), 32'd0);
        end
        check("ff_bv", 32'(byte_valid), 32'd1);
        check("ff_count", 32'(got_bits.size()), 32'd8);
`ifndef NRZI_DEC_EN
        check("ff_val", 32'(byte_out), 32'hFF);
`endif
        end_seg("ff");
        do_clear(1'b0, 1'b0);

        // Clear with a simultaneous bit discards the partial byte and that bit
        begin_seg();
        send(1'b1, 0);
        send(1'b0, 1);
        send(1'b1, 0);
        do_clear(1'b1, 1'b1);
        begin_seg();
        send_byte(8'h3C, 1);
`ifndef NRZI_DEC_EN
        check("c3_nbytes", 32'(got_bytes.size()), 32'd1);
        if (got_bytes.size() > 0) check("c3_val", 32'(got_bytes[0]), 32'h3C);
`endif
        end_seg("c3");
        do_clear(1'b0, 1'b0);

`ifdef NRZI_DEC_EN
        // NRZI: line 1,1,0,0,1 decodes to 1,1,0,1,0
        begin_seg();
        p = '{1, 1, 0, 0, 1};
        foreach (p[i]) send(p[i], 0);
        check("nrzi_count", 32'(got_bits.size()), 32'd5);
        if (got_bits.size() == 5) begin
            check("nrzi_b0", 32'(got_bits[0]), 32'd1);
            check("nrzi_b1", 32'(got_bits[1]), 32'd1);
            check("nrzi_b2", 32'(got_bits[2]), 32'd0);
            check("nrzi_b3", 32'(got_bits[3]), 32'd1);
            check("nrzi_b4", 32'(got_bits[4]), 32'd0);
        end
        do_clear(1'b0, 1'b0);
`endif

        // Random streams biased towards ones so stuffing and violations both occur
        for (int s = 0; s < 8; s++) begin
            int n;
            int thr;
            begin_seg();
            n = $urandom_range(30, 90);
            thr = (s % 2 == 0) ? 7 : 9;
            for (int i = 0; i < n; i++) send(($urandom_range(0, 9) < thr), $urandom_range(0, 2));
            end_seg($sformatf("rnd%0d", s));
            do_clear(1'b0, 1'b0);
        end

        // Asynchronous reset mid-byte: outputs reset before the next edge
        begin_seg();
        send_byte(8'h5A, 0);
        send(1'b1, 0);
        send(1'b1, 0);
        send(1'b0, 0);
        rst = 1'b1;
        #1;
        check_reset_outs("arst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        begin_seg();
        send_byte(8'h81, 0);
`ifndef NRZI_DEC_EN
        check("arst_nbytes", 32'(got_bytes.size()), 32'd1);
        if (got_bytes.size() > 0) check("arst_val", 32'(got_bytes[0]), 32'h81);
`endif
        end_seg("post_rst");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
